motor_move_scheduler: RTL
=========================

Name: motor_move_scheduler

Overview:
- Position-target sequencer for the bank of stepper channels; sits between the SPI command decoder and the per-motor step generators.
- Accepts "move motor m to signed target T at divider D" commands and drives each generator's divider, direction and step enable.
- Enforces a direction-setup delay before stepping and stops each motor once its reported position reaches the target.
- A single round-robin scan pointer evaluates one motor per clock.

Parameters:
- NUM_MOTORS, 6, number of channels scheduled (1..10)
- POS_W, 32, width of signed position and target
- DIV_W, 13, width of step divider
- MIN_DIV, 8, smallest divider passed to a generator; smaller requests are clamped
- DIR_SETUP, 16, clocks between a direction change and step enable (>=1)

Ports:
- CLK  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command accepted when valid&ready
- cmd_motor  in  4  target channel index
- cmd_target  in  POS_W  signed target position
- cmd_divider  in  DIV_W  requested step divider
- abort  in  NUM_MOTORS  per-motor immediate stop
- cur_position  in  NUM_MOTORS*POS_W  flattened signed positions; motor m at [m*POS_W +: POS_W]
- divider  out  NUM_MOTORS*DIV_W  flattened dividers to the generators
- move_dir  out  NUM_MOTORS  1 = increasing position
- step_ena  out  NUM_MOTORS  generator step enable
- busy  out  NUM_MOTORS  motor not in IDLE, or command pending
- done  out  NUM_MOTORS  1-clock pulse when a move completes at target

Behaviour:
- Reset:
  - All outputs 0, except divider = MIN_DIV per motor.
  - Scan pointer 0; all motors IDLE; pending and setup counters cleared.
  - cmd_ready is 0 while reset is high and 1 otherwise.
- Command write, same clock as accept:
  - Write target[m] and div_req[m] = max(cmd_divider, MIN_DIV); set pending[m].
  - cmd_motor >= NUM_MOTORS: command is accepted and dropped, no side effect.
  - A second command before evaluation overwrites the first (latest wins).
- Scan:
  - ptr advances every clock and wraps NUM_MOTORS-1 -> 0.
  - Only motor ptr is evaluated; evaluation uses register values from before this clock's command write.
  - A command to the motor being visited is seen on the next visit.
  - Worst-case command-to-action latency is NUM_MOTORS clocks.
- Setup counter: set_cnt[m] decrements every clock while nonzero, independent of the scan.
- Comparisons: signed. want_up = target > cur; at_target = (dir ? cur >= target : cur <= target).
- IDLE:
  - If pending: clear it.
  - If target == cur: pulse done[m], stay IDLE.
  - Otherwise: divider[m] <= div_req, move_dir[m] <= want_up, set_cnt <= DIR_SETUP, go DIRSET.
- DIRSET:
  - step_ena = 0.
  - If pending: clear it and re-evaluate as from IDLE; the counter reloads.
  - Else if set_cnt == 0: step_ena[m] <= 1, go RUN.
- RUN, if pending: clear it.
  - target == cur: step_ena <= 0, done pulse, go IDLE.
  - want_up == move_dir: divider <= div_req and stay RUN; no re-setup, no enable glitch.
  - Otherwise: step_ena <= 0, flip move_dir, reload set_cnt, go DIRSET.
- RUN, no pending: if at_target then step_ena <= 0, done pulse, go IDLE. Overshoot is tolerated; the motor is not reversed.
- abort[m]: sampled every clock regardless of ptr and has priority over all else.
  - step_ena[m] <= 0, state IDLE, pending cleared, no done pulse.
  - A command accepted in the same clock as abort is discarded.
- done and step_ena change only on the owning motor's visit, except on abort.
- Reset mid-move: forces step_ena 0 on the next edge; targets are lost.

Decomposition:
- Package motor_sched_pkg holds:
  - state encoding IDLE/DIRSET/RUN (2 bits)
  - localparams for the POS_W/DIV_W defaults
  - the flattened-bus slice helper widths
- No sub-module: per-motor state, targets, dividers and counters are register arrays indexed by the scan pointer and the abort vector.

Test Plan:
- Reset, then cmd m=0 T=100 D=20 with cur0=0: within 6 clocks move_dir[0]=1 and step_ena[0]=0; step_ena[0] rises >=16 clocks after move_dir. Ramp cur0 to 100: step_ena falls and done[0] pulses exactly once within 6 clocks.
- cmd m=2 T=-5 (0xFFFFFFFB) D=3 with cur2=0: move_dir[2]=0 and divider[2]=8 (clamped). Signed compare must not treat the target as large positive.
- Motor 1 in RUN, up, T=500, cur=200; new cmd T=50 D=40: step_ena[1] drops, move_dir flips to 0, step_ena re-enables after >=16 clocks, divider=40. Same-direction retarget T=800 instead: step_ena stays 1 continuously.
- cmd m=3 T=cur: no step_ena, single done[3] pulse, busy[3] returns 0.
- abort[4] during DIRSET and during RUN: step_ena[4]=0 next clock, no done, busy[4]=0. abort concurrent with a cmd to motor 4 leaves it IDLE.
- Two back-to-back cmds to motor 5 in consecutive clocks: only the second target is executed, and exactly one done pulse follows. cmd_motor=12: all outputs unchanged.

Source files
------------

// File: rtl/motor_sched_pkg.sv
// rtl/motor_sched_pkg.sv - shared state encoding, widths and bus-slice helper for motor_move_scheduler
// Purpose: types and constants imported by the scheduler.
// Contents:
//   motor_state_t : per-motor sequencing state (IDLE / DIRSET / RUN)
//   DEF_POS_W     : default width of signed positions and targets
//   DEF_DIV_W     : default width of the step divider
//   CMD_MOTOR_W   : width of the command channel index
//   slice_lo()    : low bit of lane idx in a flattened bus of w-bit lanes
package motor_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRSET = 2'd1,
        ST_RUN    = 2'd2
    } motor_state_t;

    localparam int DEF_POS_W   = 32;
    localparam int DEF_DIV_W   = 13;
    localparam int CMD_MOTOR_W = 4;

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/motor_move_scheduler.sv
// rtl/motor_move_scheduler.sv - round-robin position-target sequencer for a bank of stepper channels
// Purpose: accepts "move motor m to target T at divider D" commands, sequences each
// channel through a direction-setup delay, enables stepping and stops at the target.
// One motor (the scan pointer) is evaluated per clock; abort acts on every motor every clock.
// Ports:
//   CLK, reset    : clock, synchronous active-high reset
//   cmd_valid/ready, cmd_motor, cmd_target, cmd_divider : command handshake and payload
//   abort         : per-motor immediate stop
//   cur_position  : flattened signed positions reported by the generators
//   divider       : flattened step dividers to the generators
//   move_dir      : 1 = increasing position
//   step_ena      : generator step enable
//   busy          : motor not idle or command pending
//   done          : one-clock pulse when a move completes at target
module motor_move_scheduler
    import motor_sched_pkg::*;
#(
    parameter int NUM_MOTORS = 6,
    parameter int POS_W      = DEF_POS_W,
    parameter int DIV_W      = DEF_DIV_W,
    parameter int MIN_DIV    = 8,
    parameter int DIR_SETUP  = 16
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [CMD_MOTOR_W-1:0]      cmd_motor,
    input  logic [POS_W-1:0]            cmd_target,
    input  logic [DIV_W-1:0]            cmd_divider,
    input  logic [NUM_MOTORS-1:0]       abort,
    input  logic [NUM_MOTORS*POS_W-1:0] cur_position,
    output logic [NUM_MOTORS*DIV_W-1:0] divider,
    output logic [NUM_MOTORS-1:0]       move_dir,
    output logic [NUM_MOTORS-1:0]       step_ena,
    output logic [NUM_MOTORS-1:0]       busy,
    output logic [NUM_MOTORS-1:0]       done
);

    localparam int PTR_W = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
    localparam int SC_W  = $clog2(DIR_SETUP + 1);

    // Per-motor register arrays
    motor_state_t             r_state   [NUM_MOTORS];
    logic signed [POS_W-1:0]  r_target  [NUM_MOTORS];
    logic [DIV_W-1:0]         r_div_req [NUM_MOTORS];
    logic [DIV_W-1:0]         r_divider [NUM_MOTORS];
    logic [SC_W-1:0]          r_set_cnt [NUM_MOTORS];
    logic [NUM_MOTORS-1:0]    r_pending;
    logic [NUM_MOTORS-1:0]    r_dir;
    logic [NUM_MOTORS-1:0]    r_step_ena;
    logic [NUM_MOTORS-1:0]    r_done;
    logic [PTR_W-1:0]         r_ptr;

    logic                     w_cmd_fire;
    logic [DIV_W-1:0]         w_div_clamped;
    logic signed [POS_W-1:0]  w_cur       [NUM_MOTORS];
    logic [NUM_MOTORS-1:0]    w_want_up;
    logic [NUM_MOTORS-1:0]    w_eq;
    logic [NUM_MOTORS-1:0]    w_at_target;
    logic [NUM_MOTORS-1:0]    w_visit;
    logic [NUM_MOTORS-1:0]    w_cmd_hit;

    assign cmd_ready     = ~reset;
    assign w_cmd_fire    = cmd_valid & cmd_ready;
    assign w_div_clamped = (cmd_divider < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cmd_divider;

    assign move_dir = r_dir;
    assign step_ena = r_step_ena;
    assign done     = r_done;

    for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_lane
        assign w_cur[g]       = $signed(cur_position[slice_lo(g, POS_W) +: POS_W]);
        assign w_want_up[g]   = r_target[g] > w_cur[g];
        assign w_eq[g]        = r_target[g] == w_cur[g];
        // Overshoot counts as arrival; the motor is never driven back.
        assign w_at_target[g] = r_dir[g] ? (w_cur[g] >= r_target[g])
                                         : (w_cur[g] <= r_target[g]);
        assign w_visit[g]     = (r_ptr == PTR_W'(g));
        // Out-of-range channel indices match no lane, so they are accepted and dropped.
        assign w_cmd_hit[g]   = w_cmd_fire && (cmd_motor == CMD_MOTOR_W'(g));
        assign divider[slice_lo(g, DIV_W) +: DIV_W] = r_divider[g];
        assign busy[g]        = (r_state[g] != ST_IDLE) || r_pending[g];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_ptr      <= '0;
            r_pending  <= '0;
            r_dir      <= '0;
            r_step_ena <= '0;
            r_done     <= '0;
            for (int m = 0; m < NUM_MOTORS; m++) begin
                r_state[m]   <= ST_IDLE;
                r_target[m]  <= '0;
                r_div_req[m] <= DIV_W'(MIN_DIV);
                r_divider[m] <= DIV_W'(MIN_DIV);
                r_set_cnt[m] <= '0;
            end
        end else begin
            r_ptr  <= (r_ptr == PTR_W'(NUM_MOTORS - 1)) ? '0 : r_ptr + 1'b1;
            r_done <= '0;
            for (int m = 0; m < NUM_MOTORS; m++) begin
                // Setup countdown runs every clock; a reload below overrides it.
                if (r_set_cnt[m] != '0) begin
                    r_set_cnt[m] <= r_set_cnt[m] - 1'b1;
                end
                if (abort[m]) begin
                    // Abort wins over the visit and over a same-clock command.
                    r_step_ena[m] <= 1'b0;
                    r_state[m]    <= ST_IDLE;
                    r_pending[m]  <= 1'b0;
                end else begin
                    if (w_visit[m]) begin
                        case (r_state[m])
                            ST_IDLE, ST_DIRSET: begin
                                if (r_pending[m]) begin
                                    r_pending[m] <= 1'b0;
                                    if (w_eq[m]) begin
                                        r_done[m]  <= 1'b1;
                                        r_state[m] <= ST_IDLE;
                                    end else begin
                                        r_divider[m] <= r_div_req[m];
                                        r_dir[m]     <= w_want_up[m];
                                        r_set_cnt[m] <= SC_W'(DIR_SETUP);
                                        r_state[m]   <= ST_DIRSET;
                                    end
                                end else if ((r_state[m] == ST_DIRSET) && (r_set_cnt[m] == '0)) begin
                                    r_step_ena[m] <= 1'b1;
                                    r_state[m]    <= ST_RUN;
                                end
                            end
                            ST_RUN: begin
                                if (r_pending[m]) begin
                                    r_pending[m] <= 1'b0;
                                    if (w_eq[m]) begin
                                        r_step_ena[m] <= 1'b0;
                                        r_done[m]     <= 1'b1;
                                        r_state[m]    <= ST_IDLE;
                                    end else if (w_want_up[m] == r_dir[m]) begin
                                        // Same direction: retune speed without pausing.
                                        r_divider[m] <= r_div_req[m];
                                    end else begin
                                        // Reversal: stop, flip, and wait out the setup again.
                                        r_step_ena[m] <= 1'b0;
                                        r_dir[m]      <= ~r_dir[m];
                                        r_divider[m]  <= r_div_req[m];
                                        r_set_cnt[m]  <= SC_W'(DIR_SETUP);
                                        r_state[m]    <= ST_DIRSET;
                                    end
                                end else if (w_at_target[m]) begin
                                    r_step_ena[m] <= 1'b0;
                                    r_done[m]     <= 1'b1;
                                    r_state[m]    <= ST_IDLE;
                                end
                            end
                            default: begin
                                r_step_ena[m] <= 1'b0;
                                r_state[m]    <= ST_IDLE;
                            end
                        endcase
                    end
                    // Written after the visit so a command landing on the visited
                    // motor survives and is picked up on its next visit.
                    if (w_cmd_hit[m]) begin
                        r_target[m]  <= $signed(cmd_target);
                        r_div_req[m] <= w_div_clamped;
                        r_pending[m] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
